pio_bank_irq: RTL and testbench

Parametrised Avalon-MM peripheral-I/O bank that replaces the separate fixed-width hex, LEDR and key PIOs on the platform bus with one slave. It holds NOUT output registers of DW bits each, feeding the HEX and LEDR pins. It also provides one IW-bit input port with synchronisation, debouncing, per-bit rising/falling edge capture and a maskable level interrupt to the Nios II. It sits on the Nios data master's interconnect, clocked by the system clock.

---
 rtl/pio_pkg.sv | 27 ++
 rtl/pio_debounce.sv | 45 ++++
 rtl/pio_bank_irq.sv | 167 ++++++++++++++++
 tb/tb_pio_bank_irq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the PIO bank: register offsets, prescaler sizing, byte-lane merge.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package pio_pkg;

    // Register offsets relative to NOUT (the OUT[] block occupies 0..NOUT-1)
    localparam int OFS_IN   = 0;
    localparam int OFS_EDGE = 1;
    localparam int OFS_MASK = 2;
    localparam int OFS_RISE = 3;
    localparam int OFS_FALL = 4;

    // Prescaler counter width; DEB_CYCLES >= 2 so this is always >= 1
    function automatic int prescale_w(input int deb_cycles);
        return (deb_cycles < 2) ? 1 : $clog2(deb_cycles);
    endfunction

    // Replace the byte lanes of old_v selected by be with the matching lanes of new_v
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_v & ~m) | (new_v & m);
    endfunction

endpackage

// File: rtl/pio_debounce.sv
// Two-flop synchroniser plus tick-sampled debouncer for an IW-bit input vector.
// Latency: 2 clocks of sync, then the debounced bit follows after 1-2 ticks of stability.
// Backpressure: none; free-running, the tick is supplied by the parent.
module pio_debounce
    import pio_pkg::*;
#(
    parameter int            IW      = 8,
    parameter logic [IW-1:0] IN_INIT = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] i_raw,
    input  logic          i_tick,
    output logic [IW-1:0] o_deb
);

    logic [IW-1:0] r_sync1;
    logic [IW-1:0] r_sync2;
    logic [IW-1:0] r_samp;
    logic [IW-1:0] r_deb;
    logic [IW-1:0] w_same;

    // A bit is considered stable when this tick's sample matches the previous tick's
    assign w_same = ~(r_sync2 ^ r_samp);

    // Synchronise every clock; on a tick take a new sample and accept stable bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= IN_INIT;
            r_sync2 <= IN_INIT;
            r_samp  <= IN_INIT;
            r_deb   <= IN_INIT;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (i_tick) begin
                r_samp <= r_sync2;
                r_deb  <= (r_sync2 & w_same) | (r_deb & ~w_same);
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/pio_bank_irq.sv
// Avalon-MM PIO bank: NOUT output registers, one debounced input port with edge capture and irq.
// Latency: zero-wait writes, reads valid 1 clock after avs_read, irq 1 clock after EDGE/MASK change.
// Backpressure: none; the slave never stalls the master.
module pio_bank_irq
    import pio_pkg::*;
#(
    parameter int            DW         = 32,
    parameter int            NOUT       = 2,
    parameter int            IW         = 8,
    parameter int            DEB_CYCLES = 50000,
    parameter logic [IW-1:0] IN_INIT    = '1
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [3:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [3:0]         avs_byteenable,
    input  logic [31:0]        avs_writedata,
    output logic [31:0]        avs_readdata,
    output logic [NOUT*DW-1:0] out_export,
    input  logic [IW-1:0]      in_export,
    output logic               irq
);

    localparam int            PW      = prescale_w(DEB_CYCLES);
    localparam logic [PW-1:0] CNT_MAX = PW'(DEB_CYCLES - 1);
    localparam int            A_IN    = NOUT + OFS_IN;
    localparam int            A_EDGE  = NOUT + OFS_EDGE;
    localparam int            A_MASK  = NOUT + OFS_MASK;
    localparam int            A_RISE  = NOUT + OFS_RISE;
    localparam int            A_FALL  = NOUT + OFS_FALL;

    logic [PW-1:0] r_cnt;
    logic          w_tick;
    logic [DW-1:0] r_out     [NOUT];
    logic [DW-1:0] w_out_nxt [NOUT];
    logic [IW-1:0] r_edge;
    logic [IW-1:0] r_mask;
    logic [IW-1:0] r_rise;
    logic [IW-1:0] r_fall;
    logic [IW-1:0] r_deb_d;
    logic [IW-1:0] w_deb;
    logic [IW-1:0] w_set;
    logic [IW-1:0] w_clr;
    logic [IW-1:0] w_mask_nxt;
    logic [IW-1:0] w_rise_nxt;
    logic [IW-1:0] w_fall_nxt;
    logic [31:0]   w_addr;
    logic [31:0]   w_rd;
    logic [31:0]   r_rdata;
    logic          r_irq;

    // Byte-lane merge for an IW-bit register; lanes above IW are dropped
    function automatic logic [IW-1:0] merge_iw(input logic [IW-1:0] old_v,
                                               input logic [31:0]   new_v,
                                               input logic [3:0]    be);
        logic [31:0] t;
        t          = '0;
        t[IW-1:0]  = old_v;
        t          = be_merge(t, new_v, be);
        return t[IW-1:0];
    endfunction

    assign w_addr = {28'd0, avs_address};
    assign w_tick = (r_cnt == CNT_MAX);

    // Shared debounce prescaler, wraps at DEB_CYCLES-1
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PW'(1);
        end
    end

    pio_debounce #(
        .IW      (IW),
        .IN_INIT (IN_INIT)
    ) u_deb (
        .clk    (clk_clk),
        .rst    (reset_reset),
        .i_raw  (in_export),
        .i_tick (w_tick),
        .o_deb  (w_deb)
    );

    // Next values for written registers and the W1C clear mask
    always_comb begin
        logic [31:0] v;
        for (int k = 0; k < NOUT; k++) begin
            v            = '0;
            v[DW-1:0]    = r_out[k];
            v            = be_merge(v, avs_writedata, avs_byteenable);
            w_out_nxt[k] = v[DW-1:0];
        end
        w_mask_nxt = merge_iw(r_mask, avs_writedata, avs_byteenable);
        w_rise_nxt = merge_iw(r_rise, avs_writedata, avs_byteenable);
        w_fall_nxt = merge_iw(r_fall, avs_writedata, avs_byteenable);
        w_clr      = '0;
        if (avs_write && (w_addr == 32'(A_EDGE))) begin
            w_clr = merge_iw('0, avs_writedata, avs_byteenable);
        end
    end

    // Qualified debounced transitions, seen one cycle after the debounced bit moves
    assign w_set = (r_rise & w_deb & ~r_deb_d) | (r_fall & ~w_deb & r_deb_d);

    // Register file, edge capture (set beats clear) and registered irq
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int k = 0; k < NOUT; k++) begin
                r_out[k] <= '0;
            end
            r_edge  <= '0;
            r_mask  <= '0;
            r_rise  <= '0;
            r_fall  <= '1;
            r_deb_d <= IN_INIT;
            r_irq   <= 1'b0;
        end else begin
            for (int k = 0; k < NOUT; k++) begin
                if (avs_write && (w_addr == 32'(k))) begin
                    r_out[k] <= w_out_nxt[k];
                end
            end
            if (avs_write && (w_addr == 32'(A_MASK))) r_mask <= w_mask_nxt;
            if (avs_write && (w_addr == 32'(A_RISE))) r_rise <= w_rise_nxt;
            if (avs_write && (w_addr == 32'(A_FALL))) r_fall <= w_fall_nxt;
            r_edge  <= (r_edge & ~w_clr) | w_set;
            r_deb_d <= w_deb;
            r_irq   <= |(r_edge & r_mask);
        end
    end

    // Read mux; unmapped words and bits above DW/IW return zero
    always_comb begin
        w_rd = '0;
        for (int k = 0; k < NOUT; k++) begin
            if (w_addr == 32'(k)) w_rd[DW-1:0] = r_out[k];
        end
        if (w_addr == 32'(A_IN))   w_rd[IW-1:0] = w_deb;
        if (w_addr == 32'(A_EDGE)) w_rd[IW-1:0] = r_edge;
        if (w_addr == 32'(A_MASK)) w_rd[IW-1:0] = r_mask;
        if (w_addr == 32'(A_RISE)) w_rd[IW-1:0] = r_rise;
        if (w_addr == 32'(A_FALL)) w_rd[IW-1:0] = r_fall;
    end

    // Read data register, holds between reads
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_rdata <= '0;
        end else if (avs_read) begin
            r_rdata <= w_rd;
        end
    end

    for (genvar k = 0; k < NOUT; k++) begin : g_out
        assign out_export[k*DW +: DW] = r_out[k];
    end

    assign avs_readdata = r_rdata;
    assign irq          = r_irq;

endmodule

// File: tb/tb_pio_bank_irq.sv
// Self-checking bench for pio_bank_irq: directed register-map scenarios plus randomized traffic.
// Latency: compares every cycle against an index-based model of the input path and register map.
// Backpressure: n/a.
module tb_pio_bank_irq;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [63:0] oexp;
    logic [7:0]  inp;
    logic        irq;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pio_bank_irq #(
        .DW(32), .NOUT(2), .IW(8), .DEB_CYCLES(DEB), .IN_INIT(8'hFF)
    ) dut (
        .clk_clk        (clk),
        .reset_reset    (rst),
        .avs_address    (addr),
        .avs_read       (rd),
        .avs_write      (wr),
        .avs_byteenable (be),
        .avs_writedata  (wd),
        .avs_readdata   (rdata),
        .out_export     (oexp),
        .in_export      (inp),
        .irq            (irq)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_out [2];
    logic [7:0]  m_deb, m_debd, m_samp, m_edge, m_mask, m_rise, m_fall;
    logic [7:0]  m_hist [4];
    logic [31:0] m_rd;
    logic        m_irq;
    int          m_e;

    function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'd0:    return m_out[0];
            4'd1:    return m_out[1];
            4'd2:    return {24'd0, m_deb};
            4'd3:    return {24'd0, m_edge};
            4'd4:    return {24'd0, m_mask};
            4'd5:    return {24'd0, m_rise};
            4'd6:    return {24'd0, m_fall};
            default: return 32'd0;
        endcase
    endfunction

    // m_e counts clock edges since reset release; the debouncer samples the raw
    // input from two edges earlier whenever m_e mod DEB == DEB-1
    always @(posedge clk) begin : model
        logic [7:0]  s, set, clr, ndeb, nsamp, nedge;
        logic [31:0] nrd, w;
        logic        nirq;
        if (rst) begin
            m_out[0] = 0; m_out[1] = 0;
            m_edge = 0; m_mask = 0; m_rise = 0; m_fall = 8'hFF;
            m_deb = 8'hFF; m_debd = 8'hFF; m_samp = 8'hFF;
            m_rd = 0; m_irq = 0; m_e = 0;
        end else begin
            s = (m_e >= 2) ? m_hist[(m_e - 2) % 4] : 8'hFF;
            m_hist[m_e % 4] = inp;
            nrd  = rd ? m_read(addr) : m_rd;
            nirq = |(m_edge & m_mask);
            set  = (m_rise & m_deb & ~m_debd) | (m_fall & ~m_deb & m_debd);
            clr  = 0;
            if (wr && addr == 4'd3) begin
                w = m_merge(32'd0, wd, be);
                clr = w[7:0];
            end
            nedge = (m_edge & ~clr) | set;
            ndeb  = m_deb;
            nsamp = m_samp;
            if (m_e % DEB == DEB - 1) begin
                for (int i = 0; i < 8; i++) if (s[i] == m_samp[i]) ndeb[i] = s[i];
                nsamp = s;
            end
            m_debd = m_deb; m_deb = ndeb; m_samp = nsamp;
            m_edge = nedge; m_irq = nirq; m_rd = nrd;
            if (wr) begin
                case (addr)
                    4'd0: m_out[0] = m_merge(m_out[0], wd, be);
                    4'd1: m_out[1] = m_merge(m_out[1], wd, be);
                    4'd4: begin w = m_merge({24'd0, m_mask}, wd, be); m_mask = w[7:0]; end
                    4'd5: begin w = m_merge({24'd0, m_rise}, wd, be); m_rise = w[7:0]; end
                    4'd6: begin w = m_merge({24'd0, m_fall}, wd, be); m_fall = w[7:0]; end
                    default: ;
                endcase
            end
            m_e++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_rdata", {32'd0, rdata}, {32'd0, m_rd});
            chk("m_irq", {63'd0, irq}, {63'd0, m_irq});
            chk("m_out", oexp, {m_out[1], m_out[0]});
        end
    end

    // ---------------- bus helpers ----------------
    task automatic wr_op(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk); addr = a; wd = d; be = b; wr = 1'b1;
        @(negedge clk); wr = 1'b0;
    endtask

    task automatic rd_op(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk); addr = a; rd = 1'b1;
        @(negedge clk); rd = 1'b0; d = rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] exp_rst [16];
        bit          found;
        int          op, bi;

        rst = 1'b1; addr = 0; rd = 0; wr = 0; be = 0; wd = 0; inp = 8'hFF;
        idle(3);
        chk_en = 1'b1;
        rst = 1'b0;

        // 1: reset state and full address sweep
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        for (int i = 0; i < 16; i++) exp_rst[i] = 32'd0;
        exp_rst[2] = 32'h0000_00FF;
        exp_rst[6] = 32'h0000_00FF;
        for (int i = 0; i < 16; i++) begin
            rd_op(4'(i), d);
            chk($sformatf("rst_rd%0d", i), {32'd0, d}, {32'd0, exp_rst[i]});
        end

        // 2: byte-enabled write to OUT[1] and an unmapped read
        wr_op(4'd1, 32'h1234_5678, 4'b0101);
        rd_op(4'd1, d);
        chk("out1_rd", {32'd0, d}, 64'h0000_0000_0034_0078);
        chk("out1_pin", {32'd0, oexp[63:32]}, 64'h0000_0000_0034_0078);
        rd_op(4'd9, d);
        chk("unmapped", {32'd0, d}, 64'd0);

        // 3: held low debounces and captures a fall; short pulse is rejected
        @(negedge clk); inp[0] = 1'b0;
        idle(12);
        rd_op(4'd2, d); chk("in_fe", {32'd0, d}, 64'hFE);
        rd_op(4'd3, d); chk("edge_fall", {32'd0, d}, 64'h01);
        @(negedge clk); inp[0] = 1'b1;
        idle(12);
        @(negedge clk); inp[0] = 1'b0;
        idle(3);
        inp[0] = 1'b1;
        idle(12);
        rd_op(4'd2, d); chk("in_glitch", {32'd0, d}, 64'hFF);
        rd_op(4'd3, d); chk("edge_glitch", {32'd0, d}, 64'h01);

        // 4: masked irq, W1C clear, then clear colliding with a fresh set
        wr_op(4'd4, 32'h01, 4'hF);
        @(negedge clk);
        chk("irq_on", {63'd0, irq}, 64'd1);
        wr_op(4'd3, 32'h01, 4'hF);
        chk("irq_hold", {63'd0, irq}, 64'd1);
        @(negedge clk);
        chk("irq_off", {63'd0, irq}, 64'd0);
        @(negedge clk); inp[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (m_deb[0] == 1'b0 && m_debd[0] == 1'b1) found = 1'b1;
        end
        chk("align", {63'd0, found}, 64'd1);
        addr = 4'd3; wd = 32'h01; be = 4'hF; wr = 1'b1;
        @(negedge clk); wr = 1'b0;
        rd_op(4'd3, d); chk("set_wins", {32'd0, d}, 64'h01);

        // 5: rise-only capture on bit 1
        wr_op(4'd5, 32'h02, 4'hF);
        wr_op(4'd6, 32'h00, 4'hF);
        wr_op(4'd3, 32'hFF, 4'hF);
        @(negedge clk); inp[1] = 1'b0;
        idle(12);
        @(negedge clk); inp[1] = 1'b1;
        idle(12);
        rd_op(4'd3, d); chk("rise_only", {32'd0, d}, 64'h02);

        // 6: reset in the middle of a debounce
        @(negedge clk); inp = 8'hFF;
        idle(12);
        @(negedge clk); inp[2] = 1'b0;
        idle(5);
        rst = 1'b1; inp = 8'hFF;
        idle(2);
        rst = 1'b0;
        idle(20);
        rd_op(4'd2, d); chk("rst_mid_in", {32'd0, d}, 64'hFF);
        rd_op(4'd3, d); chk("rst_mid_edge", {32'd0, d}, 64'h00);
        chk("rst_mid_out", oexp, 64'd0);
        chk("rst_mid_irq", {63'd0, irq}, 64'd0);

        // Randomized traffic checked by the model every cycle
        repeat (3000) begin
            @(negedge clk);
            rd = 1'b0; wr = 1'b0;
            op   = int'($urandom_range(0, 3));
            addr = 4'($urandom_range(0, 15));
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            if (op == 1) rd = 1'b1;
            else if (op == 2) wr = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                bi = int'($urandom_range(0, 7));
                inp[bi] = ~inp[bi];
            end
            rst = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk); rd = 1'b0; wr = 1'b0; rst = 1'b0;
        idle(2);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
